// File: rtl/load_store_unit.sv
// Memory-access stage: turns an ALU address plus rs2 data into one request/ack
// bus transaction, formats load data and flags misaligned/illegal/timed-out accesses.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        lsu_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic        bus_ren,
  output logic        bus_wen,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addrLo;
  logic             r_isLoad;

  logic        w_req;
  logic        w_err;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadFmt;

  assign w_req     = mem_read | mem_write;
  assign w_timeout = (r_count == CNT_LIMIT);

  // Width legality, alignment and direction conflicts all resolve to an error
  // that skips the bus entirely.
  always_comb begin
    w_err = 1'b0;
    case (funct3)
      3'b000:         w_err = 1'b0;
      3'b001:         w_err = alu_result[0];
      3'b010:         w_err = (alu_result[1:0] != 2'b00);
      3'b100:         w_err = mem_write;
      3'b101:         w_err = mem_write | alu_result[0];
      default:        w_err = 1'b1;
    endcase
    if (mem_read && mem_write) w_err = 1'b1;
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu_result[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_byte = bus_rdata[8*r_addrLo +: 8];
  assign w_half = r_addrLo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    case (r_funct3)
      3'b000:  w_loadFmt = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_loadFmt = {{16{w_half[15]}}, w_half};
      3'b100:  w_loadFmt = {24'h0, w_byte};
      3'b101:  w_loadFmt = {16'h0, w_half};
      default: w_loadFmt = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      IDLE: begin
        stall = w_req;
        if (w_req) w_next = w_err ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (bus_ack || w_timeout) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath and registered bus outputs; done/lsu_err default low so they pulse.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_count   <= '0;
      r_funct3  <= 3'b000;
      r_addrLo  <= 2'b00;
      r_isLoad  <= 1'b0;
      done      <= 1'b0;
      lsu_err   <= 1'b0;
      load_data <= 32'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_be    <= 4'b0000;
      bus_ren   <= 1'b0;
      bus_wen   <= 1'b0;
    end else begin
      done    <= 1'b0;
      lsu_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_req) begin
            r_funct3  <= funct3;
            r_addrLo  <= alu_result[1:0];
            r_isLoad  <= mem_read;
            bus_addr  <= {alu_result[31:2], 2'b00};
            bus_wdata <= w_wdata;
            bus_be    <= w_be;
            if (w_err) begin
              done      <= 1'b1;
              lsu_err   <= 1'b1;
              load_data <= 32'h0;
            end else begin
              bus_ren <= mem_read;
              bus_wen <= mem_write;
            end
          end
        end
        BUSY: begin
          if (bus_ack) begin
            bus_ren   <= 1'b0;
            bus_wen   <= 1'b0;
            done      <= 1'b1;
            load_data <= r_isLoad ? w_loadFmt : 32'h0;
            r_count   <= '0;
          end else if (w_timeout) begin
            bus_ren   <= 1'b0;
            bus_wen   <= 1'b0;
            done      <= 1'b1;
            lsu_err   <= 1'b1;
            load_data <= 32'h0;
            r_count   <= '0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        DONE:    r_count <= '0;
        default: r_count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: loads, stores, error
// paths, bus timeout and mid-access reset with hand-computed expectations.
module tb_load_store_unit;

  logic        clk;
  logic        nRst;
  logic [31:0] aluResult;
  logic [31:0] storeData;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic        stall;
  logic        done;
  logic [31:0] loadData;
  logic        lsuErr;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busBe;
  logic        busRen;
  logic        busWen;
  logic [31:0] busRdata;
  logic        busAck;

  int checkCount;
  int errorCount;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .alu_result (aluResult),
    .store_data (storeData),
    .mem_read   (memRead),
    .mem_write  (memWrite),
    .funct3     (funct3),
    .stall      (stall),
    .done       (done),
    .load_data  (loadData),
    .lsu_err    (lsuErr),
    .bus_addr   (busAddr),
    .bus_wdata  (busWdata),
    .bus_be     (busBe),
    .bus_ren    (busRen),
    .bus_wen    (busWen),
    .bus_rdata  (busRdata),
    .bus_ack    (busAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data);
    memRead   = rd;
    memWrite  = wr;
    funct3    = f3;
    aluResult = addr;
    storeData = data;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Load with bus_ack in the first BUSY cycle.
  task automatic runLoad(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [3:0] expBe, input logic [31:0] expData,
                         input logic [31:0] expAddr);
    applyStimulus(1'b1, 1'b0, f3, addr, 32'h0);
    #1 checkOutput({tag, " stall c0"}, stall, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput({tag, " ren c1"}, busRen, 1);
    checkOutput({tag, " wen c1"}, busWen, 0);
    checkOutput({tag, " addr"}, busAddr, expAddr);
    checkOutput({tag, " be"}, busBe, expBe);
    checkOutput({tag, " stall c1"}, stall, 1);
    busAck = 1'b1;
    busRdata = rdata;
    tick();
    busAck = 1'b0;
    busRdata = 32'h0;
    #1;
    checkOutput({tag, " done c2"}, done, 1);
    checkOutput({tag, " err c2"}, lsuErr, 0);
    checkOutput({tag, " data"}, loadData, expData);
    checkOutput({tag, " ren c2"}, busRen, 0);
    checkOutput({tag, " stall c2"}, stall, 0);
    tick();
    checkOutput({tag, " done c3"}, done, 0);
    checkOutput({tag, " data hold"}, loadData, expData);
  endtask

  task automatic runError(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr);
    applyStimulus(rd, wr, f3, addr, 32'h5555_AAAA);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " err"}, lsuErr, 1);
    checkOutput({tag, " ren"}, busRen, 0);
    checkOutput({tag, " wen"}, busWen, 0);
    checkOutput({tag, " data"}, loadData, 0);
    checkOutput({tag, " stall"}, stall, 0);
    tick();
    checkOutput({tag, " done off"}, done, 0);
    checkOutput({tag, " err off"}, lsuErr, 0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    nRst = 1'b0;
    busAck = 1'b0;
    busRdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    tick();
    tick();
    checkOutput("reset done", done, 0);
    checkOutput("reset err", lsuErr, 0);
    checkOutput("reset data", loadData, 0);
    checkOutput("reset addr", busAddr, 0);
    checkOutput("reset wdata", busWdata, 0);
    checkOutput("reset be", busBe, 0);
    checkOutput("reset ren", busRen, 0);
    checkOutput("reset wen", busWen, 0);
    checkOutput("reset stall", stall, 0);
    nRst = 1'b1;
    tick();

    runLoad("LW", 32'h0000_1004, 3'b010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h0000_1004);
    runLoad("LB", 32'h0000_1003, 3'b000, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80, 32'h0000_1000);
    runLoad("LBU", 32'h0000_1003, 3'b100, 32'h8012_3456, 4'b1000, 32'h0000_0080, 32'h0000_1000);
    runLoad("LB1", 32'h0000_1001, 3'b000, 32'h0000_7F00, 4'b0010, 32'h0000_007F, 32'h0000_1000);
    runLoad("LH", 32'h0000_1002, 3'b001, 32'h8001_3456, 4'b1100, 32'hFFFF_8001, 32'h0000_1000);
    runLoad("LHU", 32'h0000_1000, 3'b101, 32'h1234_F00D, 4'b0011, 32'h0000_F00D, 32'h0000_1000);

    // SB with ack delayed three cycles
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_2002, 32'h1234_56AB);
    #1 checkOutput("SB stall c0", stall, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput("SB wdata", busWdata, 32'hABAB_ABAB);
    checkOutput("SB be", busBe, 4'b0100);
    checkOutput("SB addr", busAddr, 32'h0000_2000);
    checkOutput("SB ren", busRen, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("SB wen wait", busWen, 1);
      checkOutput("SB stall wait", stall, 1);
      checkOutput("SB done wait", done, 0);
      tick();
    end
    checkOutput("SB wen ack", busWen, 1);
    busAck = 1'b1;
    tick();
    busAck = 1'b0;
    #1;
    checkOutput("SB done", done, 1);
    checkOutput("SB err", lsuErr, 0);
    checkOutput("SB wen off", busWen, 0);
    checkOutput("SB data", loadData, 0);
    tick();

    // SH on the upper halfword
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_2006, 32'h0000_BEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput("SH wdata", busWdata, 32'hBEEF_BEEF);
    checkOutput("SH be", busBe, 4'b1100);
    checkOutput("SH wen", busWen, 1);
    busAck = 1'b1;
    tick();
    busAck = 1'b0;
    checkOutput("SH done", done, 1);
    tick();

    runError("LH misaligned", 1'b1, 1'b0, 3'b001, 32'h0000_3001);
    runError("funct3 011", 1'b1, 1'b0, 3'b011, 32'h0000_3000);
    runError("rd and wr", 1'b1, 1'b1, 3'b010, 32'h0000_3000);
    runError("SBU store", 1'b0, 1'b1, 3'b100, 32'h0000_3000);
    runError("LW misaligned", 1'b1, 1'b0, 3'b010, 32'h0000_3002);

    // Timeout: no ack for 16 BUSY cycles
    runLoad("LW pre", 32'h0000_4000, 3'b010, 32'h1111_2222, 4'b1111, 32'h1111_2222, 32'h0000_4000);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("TO ren cyc %0d", i + 1), busRen, 1);
      checkOutput($sformatf("TO done cyc %0d", i + 1), done, 0);
      tick();
    end
    checkOutput("TO done", done, 1);
    checkOutput("TO err", lsuErr, 1);
    checkOutput("TO ren off", busRen, 0);
    checkOutput("TO data", loadData, 0);
    busAck = 1'b1;
    busRdata = 32'hFFFF_FFFF;
    tick();
    checkOutput("late ack done", done, 0);
    checkOutput("late ack err", lsuErr, 0);
    checkOutput("late ack data", loadData, 0);
    tick();
    checkOutput("late ack done2", done, 0);
    busAck = 1'b0;
    busRdata = 32'h0;

    // Reset during BUSY
    runLoad("LW pre2", 32'h0000_5004, 3'b010, 32'h7777_8888, 4'b1111, 32'h7777_8888, 32'h0000_5004);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1 checkOutput("RST ren before", busRen, 1);
    nRst = 1'b0;
    tick();
    checkOutput("RST ren", busRen, 0);
    checkOutput("RST stall", stall, 0);
    checkOutput("RST data", loadData, 0);
    nRst = 1'b1;
    busAck = 1'b1;
    tick();
    busAck = 1'b0;
    checkOutput("RST ack ignored", done, 0);
    runLoad("LW post", 32'h0000_5008, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h0000_5008);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
